cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 16-bit CPU: the control end of the alu and pc interfaces.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_ctrl_decode.sv | 36 +++
 rtl/cpu_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU selects, state codes and instruction field positions for the CPU controller.
package cpu_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned OP_SIZE    = 4;
    localparam int unsigned REG_ADDR_W = 4;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RS_MSB = 7;
    localparam int unsigned RS_LSB = 4;
    localparam int unsigned RT_MSB = 3;
    localparam int unsigned RT_LSB = 0;

    localparam logic [OP_SIZE-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_SIZE-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_SIZE-1:0] OP_BEQ  = 4'hC;
    localparam logic [OP_SIZE-1:0] OP_JMP  = 4'hD;
    localparam logic [OP_SIZE-1:0] OP_NOP  = 4'hE;
    localparam logic [OP_SIZE-1:0] OP_HALT = 4'hF;

    localparam logic [OP_SIZE-1:0] ALU_SUB = 4'h1;

    localparam logic [WORD_SIZE-1:0] INSTR_NOP = 16'hE000;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXEC      = 3'd3,
        ST_WB        = 3'd4,
        ST_HALT      = 3'd5,
        ST_STEP_WAIT = 3'd6
    } state_t;

    function automatic logic [WORD_SIZE-1:0] sext_off4(input logic [3:0] off);
        return {{(WORD_SIZE-4){off[3]}}, off};
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier: every one of the 16 opcodes maps to exactly one class.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OP_SIZE-1:0] i_op,
    output logic               o_is_alu,
    output logic               o_is_beq,
    output logic               o_is_jmp,
    output logic               o_is_nop,
    output logic               o_is_halt,
    output logic [OP_SIZE-1:0] o_alu_sel
);

    always_comb begin
        o_is_alu  = 1'b0;
        o_is_beq  = 1'b0;
        o_is_jmp  = 1'b0;
        o_is_nop  = 1'b0;
        o_is_halt = 1'b0;
        o_alu_sel = '0;
        case (i_op)
            OP_BEQ: begin
                o_is_beq  = 1'b1;
                o_alu_sel = ALU_SUB;
            end
            OP_JMP:  o_is_jmp  = 1'b1;
            OP_NOP:  o_is_nop  = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: begin
                o_is_alu  = 1'b1;
                o_alu_sel = i_op;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 16-bit CPU.
// Optional single-step gating before each fetch: define CTRL_STEP_EN.
module cpu_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WORD_SIZE-1:0]  i_pc_counter,
    output logic                  o_imem_req,
    input  logic                  i_imem_ack,
    input  logic [WORD_SIZE-1:0]  i_imem_data,
    output logic [REG_ADDR_W-1:0] o_rf_ra1,
    output logic [REG_ADDR_W-1:0] o_rf_ra2,
    input  logic [WORD_SIZE-1:0]  i_rf_rd1,
    input  logic [WORD_SIZE-1:0]  i_rf_rd2,
    output logic [REG_ADDR_W-1:0] o_rf_wa,
    output logic                  o_rf_we,
    output logic [WORD_SIZE-1:0]  o_rf_wd,
    output logic [WORD_SIZE-1:0]  o_alu_data_1,
    output logic [WORD_SIZE-1:0]  o_alu_data_2,
    output logic [OP_SIZE-1:0]    o_alu_sel,
    input  logic [WORD_SIZE-1:0]  i_alu_out,
    input  logic                  i_alu_zero_flag,
    output logic                  o_pc_inc,
    output logic                  o_pc_load,
    output logic [WORD_SIZE-1:0]  o_pc_load_val,
    input  logic                  i_step,
    output logic                  o_halted,
    output logic [2:0]            o_state_dbg
);

    state_t                r_state;
    logic [WORD_SIZE-1:0]  r_ir;
    logic                  r_imem_req;
    logic [REG_ADDR_W-1:0] r_rf_ra1;
    logic [REG_ADDR_W-1:0] r_rf_ra2;
    logic [REG_ADDR_W-1:0] r_rf_wa;
    logic                  r_rf_we;
    logic [WORD_SIZE-1:0]  r_rf_wd;
    logic [WORD_SIZE-1:0]  r_alu_data_1;
    logic [WORD_SIZE-1:0]  r_alu_data_2;
    logic [OP_SIZE-1:0]    r_alu_sel;
    logic                  r_pc_inc;
    logic                  r_pc_load;
    logic [WORD_SIZE-1:0]  r_pc_load_val;
    logic                  r_halted;

    logic                  w_is_alu;
    logic                  w_is_beq;
    logic                  w_is_jmp;
    logic                  w_is_nop;
    logic                  w_is_halt;
    logic [OP_SIZE-1:0]    w_alu_sel;
    logic                  w_step_rise;

    cpu_ctrl_decode u_decode (
        .i_op      (r_ir[OP_MSB:OP_LSB]),
        .o_is_alu  (w_is_alu),
        .o_is_beq  (w_is_beq),
        .o_is_jmp  (w_is_jmp),
        .o_is_nop  (w_is_nop),
        .o_is_halt (w_is_halt),
        .o_alu_sel (w_alu_sel)
    );

`ifdef CTRL_STEP_EN
    logic r_step_prev;

    assign w_step_rise = i_step & ~r_step_prev;
`else
    logic w_unused_step;

    assign w_unused_step = i_step;
    assign w_step_rise   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RESET;
            r_ir          <= INSTR_NOP;
            r_imem_req    <= 1'b0;
            r_rf_ra1      <= '0;
            r_rf_ra2      <= '0;
            r_rf_wa       <= '0;
            r_rf_we       <= 1'b0;
            r_rf_wd       <= '0;
            r_alu_data_1  <= '0;
            r_alu_data_2  <= '0;
            r_alu_sel     <= '0;
            r_pc_inc      <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_load_val <= '0;
            r_halted      <= 1'b0;
`ifdef CTRL_STEP_EN
            r_step_prev   <= 1'b0;
`endif
        end else begin
`ifdef CTRL_STEP_EN
            r_step_prev <= i_step;
`endif
            // Strobes live for exactly one cycle unless re-armed below.
            r_rf_we   <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_load <= 1'b0;
            case (r_state)
                ST_RESET: begin
`ifdef CTRL_STEP_EN
                    r_state <= ST_STEP_WAIT;
`else
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
`endif
                end
                ST_STEP_WAIT: begin
                    if (w_step_rise) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (i_imem_ack) begin
                        r_ir       <= i_imem_data;
                        r_rf_ra1   <= i_imem_data[RS_MSB:RS_LSB];
                        r_rf_ra2   <= i_imem_data[RT_MSB:RT_LSB];
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else if (w_is_nop) begin
                        r_pc_inc <= 1'b1;
                        r_state  <= ST_WB;
                    end else begin
                        r_alu_data_1 <= i_rf_rd1;
                        r_alu_data_2 <= i_rf_rd2;
                        r_alu_sel    <= w_alu_sel;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_WB;
                    r_rf_wa <= r_ir[RD_MSB:RD_LSB];
                    if (w_is_alu) begin
                        r_rf_we  <= 1'b1;
                        r_rf_wd  <= i_alu_out;
                        r_pc_inc <= 1'b1;
                    end else if (w_is_beq) begin
                        if (i_alu_zero_flag) begin
                            r_pc_load     <= 1'b1;
                            r_pc_load_val <= i_pc_counter + sext_off4(r_ir[RT_MSB:RT_LSB]);
                        end else begin
                            r_pc_inc <= 1'b1;
                        end
                    end else if (w_is_jmp) begin
                        r_pc_load     <= 1'b1;
                        r_pc_load_val <= {4'h0, r_ir[RD_MSB:RT_LSB]};
                    end
                end
                ST_WB: begin
`ifdef CTRL_STEP_EN
                    r_state <= ST_STEP_WAIT;
`else
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
`endif
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RESET;
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_rf_ra1      = r_rf_ra1;
    assign o_rf_ra2      = r_rf_ra2;
    assign o_rf_wa       = r_rf_wa;
    assign o_rf_we       = r_rf_we;
    assign o_rf_wd       = r_rf_wd;
    assign o_alu_data_1  = r_alu_data_1;
    assign o_alu_data_2  = r_alu_data_2;
    assign o_alu_sel     = r_alu_sel;
    assign o_pc_inc      = r_pc_inc;
    assign o_pc_load     = r_pc_load;
    assign o_pc_load_val = r_pc_load_val;
    assign o_halted      = r_halted;
    assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed, table-driven bench for cpu_ctrl_fsm with a behavioural register file and ALU.
// Also exercises the CTRL_STEP_EN build when that macro is defined.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_counter;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  rf_ra1, rf_ra2, rf_wa;
    logic [15:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [15:0] alu_data_1, alu_data_2, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_zero_flag;
    logic        pc_inc, pc_load;
    logic [15:0] pc_load_val;
    logic        step;
    logic        halted;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pc_counter    (pc_counter),
        .o_imem_req      (imem_req),
        .i_imem_ack      (imem_ack),
        .i_imem_data     (imem_data),
        .o_rf_ra1        (rf_ra1),
        .o_rf_ra2        (rf_ra2),
        .i_rf_rd1        (rf_rd1),
        .i_rf_rd2        (rf_rd2),
        .o_rf_wa         (rf_wa),
        .o_rf_we         (rf_we),
        .o_rf_wd         (rf_wd),
        .o_alu_data_1    (alu_data_1),
        .o_alu_data_2    (alu_data_2),
        .o_alu_sel       (alu_sel),
        .i_alu_out       (alu_out),
        .i_alu_zero_flag (alu_zero_flag),
        .o_pc_inc        (pc_inc),
        .o_pc_load       (pc_load),
        .o_pc_load_val   (pc_load_val),
        .i_step          (step),
        .o_halted        (halted),
        .o_state_dbg     (state_dbg)
    );

    // Register file: r1=5, r2=3, r4=0x00F0, r5=0x000F, r14=5, rest 0.
    logic [15:0] rf_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;
        rf_mem[1]  = 16'h0005;
        rf_mem[2]  = 16'h0003;
        rf_mem[4]  = 16'h00F0;
        rf_mem[5]  = 16'h000F;
        rf_mem[14] = 16'h0005;
    end
    assign rf_rd1 = rf_mem[rf_ra1];
    assign rf_rd2 = rf_mem[rf_ra2];

    always_comb begin
        case (alu_sel)
            4'h0:    alu_out = alu_data_1 + alu_data_2;
            4'h1:    alu_out = alu_data_1 - alu_data_2;
            4'h2:    alu_out = alu_data_1 & alu_data_2;
            4'h3:    alu_out = alu_data_1 | alu_data_2;
            default: alu_out = alu_data_1 ^ alu_data_2;
        endcase
    end
    assign alu_zero_flag = (alu_out == 16'h0000);

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        int          wait_cyc;
        bit          stray;
        bit          exp_we;
        logic [3:0]  exp_wa;
        logic [15:0] exp_wd;
        bit          exp_inc;
        bit          exp_load;
        logic [15:0] exp_lv;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!imem_req && n < 30) begin
`ifdef CTRL_STEP_EN
            step = (n == 2);
`endif
            @(negedge clk);
            n++;
        end
`ifdef CTRL_STEP_EN
        step = 1'b0;
`endif
        ok = imem_req;
    endtask

    task automatic do_fetch(input logic [15:0] instr, input int wait_cyc);
        bit ok;
        int reqs = 0;
        wait_req(ok);
        chk("req_seen", {31'd0, ok}, 1);
        for (int k = 0; k <= wait_cyc; k++) begin
            if (k == 0) chk("no_pulse_in_fetch", {29'd0, pc_inc, pc_load, rf_we}, 0);
            if (imem_req) reqs++;
            imem_ack  = (k == wait_cyc);
            imem_data = (k == wait_cyc) ? instr : ~instr;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("req_cycles", reqs, wait_cyc + 1);
        chk("req_drop", {31'd0, imem_req}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat = 0;
        pc_counter = v.pc;
        do_fetch(v.instr, v.wait_cyc);
        while (!(pc_inc || pc_load || halted) && lat < 10) begin
            imem_ack  = v.stray && (lat < 2);
            imem_data = 16'hDFFF;
            @(negedge clk);
            lat++;
        end
        imem_ack = 1'b0;
        chk("latency", lat, v.exp_lat);
        chk("wb_state", {29'd0, state_dbg}, 4);
        chk("pc_inc", {31'd0, pc_inc}, {31'd0, v.exp_inc});
        chk("pc_load", {31'd0, pc_load}, {31'd0, v.exp_load});
        chk("rf_we", {31'd0, rf_we}, {31'd0, v.exp_we});
        if (v.exp_we) begin
            chk("rf_wa", {28'd0, rf_wa}, {28'd0, v.exp_wa});
            chk("rf_wd", {16'd0, rf_wd}, {16'd0, v.exp_wd});
        end
        if (v.exp_load) chk("pc_load_val", {16'd0, pc_load_val}, {16'd0, v.exp_lv});
    endtask

    initial begin
        bit ok;
        int reqs;
        int n;
        int exp_after_reset;

        //            instr     pc        wt st  we wa     wd        inc ld  lv        lat
        vecs[0] = '{16'h0312, 16'h0000, 0, 0, 1, 4'h3, 16'h0008, 1, 0, 16'h0000, 2}; // ADD
        vecs[1] = '{16'h1712, 16'h0001, 1, 0, 1, 4'h7, 16'h0002, 1, 0, 16'h0000, 2}; // SUB
        vecs[2] = '{16'hC01E, 16'h0010, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 16'h000E, 2}; // BEQ taken -2
        vecs[3] = '{16'hC02E, 16'h0010, 0, 0, 0, 4'h0, 16'h0000, 1, 0, 16'h0000, 2}; // BEQ not taken
        vecs[4] = '{16'hC011, 16'hFFFF, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 16'h0000, 2}; // BEQ +1 wrap
        vecs[5] = '{16'hD123, 16'h0040, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 16'h0123, 2}; // JMP
        vecs[6] = '{16'hE000, 16'h0041, 2, 0, 0, 4'h0, 16'h0000, 1, 0, 16'h0000, 1}; // NOP
        vecs[7] = '{16'h2845, 16'h0042, 3, 1, 1, 4'h8, 16'h0000, 1, 0, 16'h0000, 2}; // AND, slow ack
        vecs[8] = '{16'hBA12, 16'h0043, 0, 0, 1, 4'hA, 16'h0006, 1, 0, 16'h0000, 2}; // XOR
        vecs[9] = '{16'h3945, 16'h0044, 0, 1, 1, 4'h9, 16'h00FF, 1, 0, 16'h0000, 2}; // OR

`ifdef CTRL_STEP_EN
        exp_after_reset = 6;
`else
        exp_after_reset = 1;
`endif

        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = 16'h0000;
        pc_counter = 16'h0000;
        step       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state_dbg}, 0);
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_strobes", {29'd0, pc_inc, pc_load, rf_we}, 0);
        chk("rst_alu_data_1", {16'd0, alu_data_1}, 0);
        chk("rst_rf_wd", {16'd0, rf_wd}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_state", {29'd0, state_dbg}, exp_after_reset);

`ifdef CTRL_STEP_EN
        reqs = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        chk("step_low_no_req", reqs, 0);
        chk("step_wait_state", {29'd0, state_dbg}, 6);
`endif

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
`ifdef CTRL_STEP_EN
            if (i == 0) begin
                reqs = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (imem_req) reqs++;
                end
                chk("one_step_one_instr", reqs, 0);
            end
`endif
        end

        // HALT stays put and ignores acks.
        do_fetch(16'hF000, 1);
        @(negedge clk);
        chk("halted", {31'd0, halted}, 1);
        chk("halt_state", {29'd0, state_dbg}, 5);
        reqs = 0;
        repeat (6) begin
            imem_ack  = 1'b1;
            imem_data = 16'h0312;
            @(negedge clk);
            if (imem_req || pc_inc || pc_load || rf_we) reqs++;
        end
        imem_ack = 1'b0;
        chk("halt_no_activity", reqs, 0);
        chk("halt_holds", {31'd0, halted}, 1);

        rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_state", {29'd0, state_dbg}, 0);
        chk("halt_rst_halted", {31'd0, halted}, 0);
        chk("halt_rst_rf_wd", {16'd0, rf_wd}, 0);
        chk("halt_rst_alu_data", {alu_data_1, alu_data_2}, 0);
        chk("halt_rst_load_val", {16'd0, pc_load_val}, 0);
        chk("halt_rst_alu_sel", {28'd0, alu_sel}, 0);
        rst = 1'b0;

        // Reset while a fetch is outstanding.
        wait_req(ok);
        chk("mid_fetch_req", {31'd0, ok}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("fetch_rst_req", {31'd0, imem_req}, 0);
        chk("fetch_rst_state", {29'd0, state_dbg}, 0);
        rst = 1'b0;

        // Reset while sitting in WB.
        pc_counter = 16'h0000;
        do_fetch(16'h0312, 0);
        n = 0;
        while (state_dbg != 3'd4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wb_reached", {29'd0, state_dbg}, 4);
        chk("wb_we_before_rst", {31'd0, rf_we}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("wb_rst_strobes", {29'd0, pc_inc, pc_load, rf_we}, 0);
        chk("wb_rst_req", {31'd0, imem_req}, 0);
        chk("wb_rst_state", {29'd0, state_dbg}, 0);
        rst = 1'b0;

        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
